// File: rtl/voice_fetch_arbiter.sv
// rtl/voice_fetch_arbiter.sv - round-robin arbiter sharing one sample-memory read port among voices
// Grants one eligible voice per cycle and returns each read tagged to its requester.
module voice_fetch_arbiter #(
  parameter int NUM_VOICES   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int SAMPLE_WIDTH = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [NUM_VOICES-1:0]            active_in,
  input  logic [NUM_VOICES-1:0]            req_in,
  input  logic [NUM_VOICES*ADDR_WIDTH-1:0] addr_in,
  input  logic                             sample_tick_in,
  input  logic                             clear_overrun_in,
  output logic [NUM_VOICES-1:0]            gnt_out,
  output logic                             mem_en_out,
  output logic [ADDR_WIDTH-1:0]            mem_addr_out,
  input  logic [SAMPLE_WIDTH-1:0]          mem_data_in,
  output logic [NUM_VOICES-1:0]            rvalid_out,
  output logic [SAMPLE_WIDTH-1:0]          rdata_out,
  output logic                             overrun_out
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_VOICES-1:0]   gnt_q, gnt_d;
  logic                    mem_en_q, mem_en_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [NUM_VOICES-1:0]   rvalid_q, rvalid_d;
  logic [SAMPLE_WIDTH-1:0] rdata_q, rdata_d;
  logic                    overrun_q, overrun_d;
  logic [IW-1:0]           last_q, last_d;
  logic [NUM_VOICES-1:0]   tag_q [READ_LATENCY];

  logic [NUM_VOICES-1:0]   eligible;
  logic                    found;
  logic [IW-1:0]           win_idx;
  logic [IW-1:0]           cand;

  // The voice granted this cycle still holds its request; mask it out.
  assign eligible = req_in & active_in & ~gnt_q;

  always_comb begin
    found   = 1'b0;
    win_idx = last_q;
    cand    = last_q;
    for (int k = 1; k <= NUM_VOICES; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_VOICES);
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_d          = '0;
    gnt_d[win_idx] = found;
    mem_en_d       = found;
    mem_addr_d     = found ? addr_in[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : mem_addr_q;
    last_d         = found ? win_idx : last_q;
    rvalid_d       = tag_q[READ_LATENCY-1];
    rdata_d        = (|tag_q[READ_LATENCY-1]) ? mem_data_in : rdata_q;
    overrun_d      = overrun_q;
    if (clear_overrun_in) overrun_d = 1'b0;
    if (sample_tick_in && (|eligible)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      overrun_q  <= 1'b0;
      last_q     <= IW'(NUM_VOICES - 1);
    end else begin
      gnt_q      <= gnt_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      overrun_q  <= overrun_d;
      last_q     <= last_d;
    end
  end

  // Tag leaves the last stage in the cycle the memory presents its data.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= gnt_q;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign gnt_out      = gnt_q;
  assign mem_en_out   = mem_en_q;
  assign mem_addr_out = mem_addr_q;
  assign rvalid_out   = rvalid_q;
  assign rdata_out    = rdata_q;
  assign overrun_out  = overrun_q;

endmodule

// File: tb/tb_voice_fetch_arbiter.sv
// tb/tb_voice_fetch_arbiter.sv - self-checking bench for voice_fetch_arbiter
// Transaction-level reference model: round-robin scan plus a queue of due returns.
module tb_voice_fetch_arbiter;
  localparam int N  = 8;
  localparam int AW = 16;
  localparam int SW = 16;
  localparam int L  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    active, req;
  logic [N*AW-1:0] addr;
  logic            tick, clr;
  logic [SW-1:0]   mem_data;
  logic [N-1:0]    gnt, rvalid;
  logic            mem_en, ovr;
  logic [AW-1:0]   mem_addr;
  logic [SW-1:0]   rdata;

  voice_fetch_arbiter #(.NUM_VOICES(N), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .READ_LATENCY(L)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .active_in(active), .req_in(req), .addr_in(addr),
    .sample_tick_in(tick), .clear_overrun_in(clr), .gnt_out(gnt), .mem_en_out(mem_en),
    .mem_addr_out(mem_addr), .mem_data_in(mem_data), .rvalid_out(rvalid), .rdata_out(rdata),
    .overrun_out(ovr)
  );

  function automatic logic [SW-1:0] memf(input logic [AW-1:0] a);
    return (a == 16'h0123) ? 16'hBEEF : ((a ^ 16'h5A5A) + 16'd7);
  endfunction

  // Synchronous memory with READ_LATENCY cycles of pipeline
  logic [AW-1:0] mp [L];
  always @(posedge clk) begin
    mp[0] <= mem_addr;
    for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
  end
  assign mem_data = memf(mp[L-1]);

  typedef struct { int due; int v; logic [AW-1:0] a; } ret_t;
  ret_t          q[$];
  logic [N-1:0]  m_gnt, m_rvalid;
  logic          m_en, m_ovr;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_rdata;
  int            m_last, ecount;
  int            nchk = 0, nfail = 0;

  task automatic model_reset();
    m_gnt = '0; m_rvalid = '0; m_en = 1'b0; m_ovr = 1'b0; m_addr = '0; m_rdata = '0;
    m_last = N - 1; q.delete();
  endtask

  task automatic model_edge();
    logic [N-1:0] elig;
    int w;
    ret_t r;
    elig = req & active & ~m_gnt;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (w < 0 && elig[idx]) w = idx;
    end
    ecount++;
    m_rvalid = '0;
    if (q.size() > 0 && q[0].due == ecount) begin
      m_rvalid[q[0].v] = 1'b1;
      m_rdata = memf(q[0].a);
      void'(q.pop_front());
    end
    if (tick && |elig) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_gnt = '0;
    m_en  = 1'b0;
    if (w >= 0) begin
      m_gnt[w] = 1'b1;
      m_en     = 1'b1;
      m_addr   = addr[w*AW +: AW];
      m_last   = w;
      r.due = ecount + L + 1; r.v = w; r.a = m_addr;
      q.push_back(r);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("mem_en", 32'(mem_en), 32'(m_en));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("overrun", 32'(ovr), 32'(m_ovr));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    tick = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic react();
    for (int i = 0; i < N; i++) begin
      if (m_gnt[i]) begin
        if ($urandom_range(1) == 0) req[i] = 1'b0;
        else addr[i*AW +: AW] = AW'($urandom);
      end else if (!req[i] && $urandom_range(2) == 0) begin
        req[i] = 1'b1;
        addr[i*AW +: AW] = AW'($urandom);
      end
    end
  endtask

  initial begin
    logic [N-1:0] e;
    rst_n = 1'b0; active = '0; req = '0; addr = '0; tick = 1'b0; clr = 1'b0;
    ecount = 0;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1; rst_n = 1'b1;

    // single request from voice 3
    active = 8'hFF; req = 8'h08; addr[3*AW +: AW] = 16'h0123;
    cyc();
    chk("t1_gnt", 32'(gnt), 32'h08);
    chk("t1_addr", 32'(mem_addr), 32'h0123);
    req = '0;
    cyc(); cyc(); cyc();
    chk("t1_rvalid", 32'(rvalid), 32'h08);
    chk("t1_rdata", 32'(rdata), 32'hBEEF);

    // all voices requesting continuously
    do_reset();
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(16'h1000 + i);
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cyc();
      e = '0; e[k % N] = 1'b1;
      chk("t2_seq", 32'(gnt), 32'(e));
      chk("t2_en", 32'(mem_en), 32'd1);
    end
    req = '0;
    repeat (L + 2) cyc();

    // active mask filters voice 0; lone voice 2 alternates
    req = 8'h05; active = 8'h04;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t3_alt", 32'(gnt), (k % 2 == 0) ? 32'h04 : 32'h00);
    end
    req = '0; active = 8'hFF;
    repeat (L + 2) cyc();

    // voice deactivated after grant still gets its return
    req = 8'h02; addr[1*AW +: AW] = 16'h2222;
    cyc();
    chk("t4_gnt", 32'(gnt), 32'h02);
    req = '0; active = 8'hFD;
    cyc(); cyc(); cyc();
    chk("t4_rvalid", 32'(rvalid), 32'h02);
    active = 8'hFF;

    // overrun set, clear, and set-beats-clear
    req = 8'hFF;
    cyc(); cyc(); cyc();
    tick = 1'b1;
    cyc();
    chk("t5_set", 32'(ovr), 32'd1);
    req = '0;
    repeat (N + L + 2) cyc();
    chk("t5_sticky", 32'(ovr), 32'd1);
    tick = 1'b1; clr = 1'b1;
    cyc();
    chk("t5_clear", 32'(ovr), 32'd0);
    req = 8'hFF; tick = 1'b1;
    cyc();
    chk("t5_reset", 32'(ovr), 32'd1);
    tick = 1'b1; clr = 1'b1;
    cyc();
    chk("t5_setwins", 32'(ovr), 32'd1);

    // reset with reads in flight
    cyc(); cyc();
    do_reset();
    cyc();
    chk("t6_first", 32'(gnt), 32'h01);
    repeat (L + 3) cyc();
    req = '0;
    repeat (L + 2) cyc();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      react();
      if ($urandom_range(19) == 0) active = N'($urandom);
      tick = ($urandom_range(15) == 0);
      clr  = ($urandom_range(7) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
